port_uart_tx: RTL and testbench

//   Memory-mapped serial transmitter on the CPU port bus, alongside the port devices.

---
 rtl/port_uart_tx.sv | 156 +++++++++++++++
 tb/tb_port_uart_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/port_uart_tx.sv
// Port-bus UART transmitter: CPU writes bytes into a small FIFO, which is drained as
// 8N1 frames on txd. The CPU polls a status word through a port read.
module port_uart_tx #(
    parameter int WORD_SIZE    = 16,
    parameter int BASE_ADDR    = 'h10,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WORD_SIZE-1:0] portaddr,
    input  logic [WORD_SIZE-1:0] portval,
    input  logic                 portget,
    input  logic                 portset,
    output logic [WORD_SIZE-1:0] portout,
    output logic                 txd,
    output logic                 busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [WORD_SIZE-1:0] DATA_ADDR  = WORD_SIZE'(BASE_ADDR);
    localparam logic [WORD_SIZE-1:0] STAT_ADDR  = WORD_SIZE'(BASE_ADDR + 1);
    localparam logic [TW-1:0]        TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]        COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [2:0]      bitcnt, bitcnt_n;
    logic [7:0]      shift, shift_n;
    logic            txd_n;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            overflow;
    logic            full, empty, push_req, push, pop, status_rd;
    logic            unused_hi;

    assign unused_hi = ^portval[WORD_SIZE-1:8];

    assign full      = (count == COUNT_FULL);
    assign empty     = (count == '0);
    assign push_req  = portset && (portaddr == DATA_ADDR);
    assign pop       = (state == IDLE) && !empty;
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    assign push      = push_req && (!full || pop);
    assign status_rd = portget && (portaddr == STAT_ADDR);
    assign busy      = (state != IDLE) || !empty;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (push_req && !push) overflow <= 1'b1;
            else if (status_rd)    overflow <= 1'b0;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; pointers and count alone define
    // which entries are valid, and leaving it reset-free lets it map to RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= portval[7:0];
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        bitcnt_n = bitcnt;
        shift_n  = shift;
        case (state)
            IDLE: begin
                if (!empty) begin
                    shift_n  = mem[rd_ptr];
                    timer_n  = '0;
                    bitcnt_n = '0;
                    state_n  = START;
                end
            end
            START: begin
                if (timer == TIMER_LAST) begin
                    timer_n = '0;
                    state_n = DATA;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            DATA: begin
                if (timer == TIMER_LAST) begin
                    timer_n  = '0;
                    shift_n  = {1'b0, shift[7:1]};
                    bitcnt_n = bitcnt + 1'b1;
                    if (bitcnt == 3'd7) state_n = STOP;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            STOP: begin
                if (timer == TIMER_LAST) begin
                    timer_n = '0;
                    state_n = IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // txd is registered from the next state so the line never glitches.
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[0];
            default: txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            timer  <= '0;
            bitcnt <= '0;
            shift  <= '0;
            txd    <= 1'b1;
        end else begin
            state  <= state_n;
            timer  <= timer_n;
            bitcnt <= bitcnt_n;
            shift  <= shift_n;
            txd    <= txd_n;
        end
    end

    always_comb begin
        portout = '0;
        if (status_rd) begin
            portout[8 +: CW] = count;
            portout[3]       = overflow;
            portout[2]       = (state != IDLE);
            portout[1]       = empty;
            portout[0]       = full;
        end
    end

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx: port-access vector table, a txd frame decoder feeding a
// scoreboard of expected bytes, and hand sequences for timing, overflow and reset.
module tb_port_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] portaddr, portval, portout;
    logic        portget, portset;
    logic        txd, busy;

    int          tests = 0;
    int          fails = 0;
    int          cyc_cnt = 0;
    bit          mon_on;
    logic [7:0]  exp_q[$];
    int          start_q[$];

    port_uart_tx #(
        .WORD_SIZE(16), .BASE_ADDR('h10), .FIFO_DEPTH(4), .CLKS_PER_BIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .portaddr(portaddr), .portval(portval),
        .portget(portget), .portset(portset), .portout(portout),
        .txd(txd), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic write_port(input logic [15:0] addr, input logic [15:0] data);
        portset  = 1'b1;
        portaddr = addr;
        portval  = data;
        @(posedge clk); #1;
        portset  = 1'b0;
    endtask

    task automatic rd_status(input logic [15:0] exp, input string name);
        portget  = 1'b1;
        portaddr = 16'h0011;
        #1;
        check(name, portout, exp);
        @(posedge clk); #1;
        portget  = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Frame decoder: samples each bit mid-cell and scores the byte against exp_q.
    initial begin : monitor
        logic [7:0] b;
        logic       start_ok, stop_bit;
        int         k;
        forever begin
            @(posedge clk); #2;
            if (txd === 1'b0) begin
                k = cyc_cnt;
                repeat (2) @(posedge clk);
                #2;
                start_ok = (txd === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(posedge clk);
                    #2;
                    b[i] = txd;
                end
                repeat (4) @(posedge clk);
                #2;
                stop_bit = txd;
                if (mon_on) begin
                    check("mon_start_bit", start_ok, 1'b1);
                    check("mon_stop_bit", stop_bit, 1'b1);
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL mon_unexpected_frame: got %02h, expected no frame", b);
                    end else begin
                        check("mon_byte", b, exp_q.pop_front());
                        start_q.push_back(k);
                    end
                end
            end
        end
    end

    typedef struct {
        logic        set;
        logic        get;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp_out;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          w, n;
        logic [40:0] exp_txd, act_txd, exp_busy, act_busy;

        vecs[0] = '{1'b0, 1'b1, 16'h0011, 16'h0000, 16'h0002, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0000, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 16'h0012, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h0011, 16'h0055, 16'h0000, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 16'h0012, 16'h0066, 16'h0000, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'h0011, 16'h0000, 16'h0002, 1'b0};

        portaddr = '0;
        portval  = '0;
        portget  = 1'b0;
        portset  = 1'b0;
        mon_on   = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle after reset: line high, not busy.
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (txd === 1'b1 && busy === 1'b0) n++;
        end
        check("idle_quiet_cycles", n, 20);

        // Port decode table, including writes to non-data addresses.
        for (int i = 0; i < 7; i++) begin
            portset  = vecs[i].set;
            portget  = vecs[i].get;
            portaddr = vecs[i].addr;
            portval  = vecs[i].data;
            #1;
            check($sformatf("vec%0d_portout", i), portout, vecs[i].exp_out);
            @(posedge clk); #1;
            portset = 1'b0;
            portget = 1'b0;
            check($sformatf("vec%0d_busy", i), {busy, txd}, {vecs[i].exp_busy, 1'b1});
        end

        // Single byte 'hA5: exact per-cycle txd and busy waveform.
        exp_q.push_back(8'hA5);
        write_port(16'h0010, 16'hFFA5);
        check("a5_busy_after_write", busy, 1'b1);
        for (int i = 1; i <= 41; i++) begin
            if (i <= 4)       exp_txd[i-1] = 1'b0;
            else if (i <= 36) exp_txd[i-1] = (8'hA5 >> ((i - 5) / 4)) & 1;
            else              exp_txd[i-1] = 1'b1;
            exp_busy[i-1] = (i <= 40);
            @(posedge clk); #1;
            act_txd[i-1]  = txd;
            act_busy[i-1] = busy;
        end
        check("a5_txd_waveform", act_txd, exp_txd);
        check("a5_busy_waveform", act_busy, exp_busy);

        // Back-to-back bytes: order and 41-cycle frame spacing.
        repeat (3) @(posedge clk);
        #1;
        start_q.delete();
        write_port(16'h0010, 16'h0001);
        w = cyc_cnt;
        write_port(16'h0010, 16'h0002);
        write_port(16'h0010, 16'h0003);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        wait_idle(200, "b2b_drain_timeout");
        check("b2b_frames", start_q.size(), 3);
        if (start_q.size() == 3) begin
            check("b2b_first_latency", start_q[0] - w, 1);
            check("b2b_spacing_1", start_q[1] - start_q[0], 41);
            check("b2b_spacing_2", start_q[2] - start_q[1], 41);
        end

        // Overflow: six writes in consecutive cycles, five accepted.
        for (int i = 0; i < 6; i++) begin
            write_port(16'h0010, 16'h0010 + 16'(i));
            if (i == 0) w = cyc_cnt;
            if (i < 5) exp_q.push_back(8'h10 + 8'(i));
        end
        rd_status(16'h040D, "ovf_status_set");
        rd_status(16'h0405, "ovf_status_cleared");

        // Full FIFO written in the very cycle the head is popped: accepted, no overflow.
        while (cyc_cnt != w + 41) begin
            @(posedge clk); #1;
        end
        portget  = 1'b1;
        portaddr = 16'h0011;
        #1;
        check("gap_idle_full_status", portout, 16'h0401);
        portget = 1'b0;
        exp_q.push_back(8'hEE);
        write_port(16'h0010, 16'h00EE);
        rd_status(16'h0405, "full_pop_push_status");
        wait_idle(400, "ovf_drain_timeout");
        check("ovf_all_frames_seen", exp_q.size(), 0);

        // Reset in the middle of a frame drops it and the queued byte.
        mon_on = 1'b0;
        write_port(16'h0010, 16'h0000);
        w = cyc_cnt;
        write_port(16'h0010, 16'h0000);
        while (cyc_cnt != w + 15) begin
            @(posedge clk); #1;
        end
        check("rst_pre_txd_low", txd, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_txd_high", txd, 1'b1);
        check("rst_busy_low", busy, 1'b0);
        rst_n = 1'b1;
        rd_status(16'h0002, "rst_status");
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (txd === 1'b1 && busy === 1'b0) n++;
        end
        check("rst_fifo_flushed", n, 60);
        mon_on = 1'b1;

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
